// File: rtl/nios_mult_pipe.sv
// nios_mult_pipe: three-stage DATA_W x DATA_W multiplier built from four
// HALF_W partial products, returning the low word (MUL) or the high word.
`default_nettype none

module nios_mult_pipe #(
  parameter int DATA_W = 32,
  localparam int HALF_W = DATA_W / 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  localparam logic [1:0] MODE_MUL    = 2'd0;
  localparam logic [1:0] MODE_MULXSU = 2'd2;
  localparam logic [1:0] MODE_MULXSS = 2'd3;

  // Halves zero-extended to DATA_W so each partial product keeps all its bits.
  logic [DATA_W-1:0] a_lo, a_hi, b_lo, b_hi;

  assign a_lo = {{HALF_W{1'b0}}, src1[HALF_W-1:0]};
  assign a_hi = {{HALF_W{1'b0}}, src1[DATA_W-1:HALF_W]};
  assign b_lo = {{HALF_W{1'b0}}, src2[HALF_W-1:0]};
  assign b_hi = {{HALF_W{1'b0}}, src2[DATA_W-1:HALF_W]};

  // Stage S1 registers
  logic              s1_valid;
  logic [DATA_W-1:0] s1_pp_ll, s1_pp_lh, s1_pp_hl, s1_pp_hh;
  logic [DATA_W-1:0] s1_a, s1_b;
  logic [1:0]        s1_mode;
  logic              s1_sign_a, s1_sign_b;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_pp_ll  <= '0;
      s1_pp_lh  <= '0;
      s1_pp_hl  <= '0;
      s1_pp_hh  <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_mode   <= MODE_MUL;
      s1_sign_a <= 1'b0;
      s1_sign_b <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_pp_ll  <= a_lo * b_lo;
        s1_pp_lh  <= a_lo * b_hi;
        s1_pp_hl  <= a_hi * b_lo;
        s1_pp_hh  <= a_hi * b_hi;
        s1_a      <= src1;
        s1_b      <= src2;
        s1_mode   <= mode;
        s1_sign_a <= src1[DATA_W-1];
        s1_sign_b <= src2[DATA_W-1];
      end
    end
  end

  // Stage S2 combinational: full unsigned product, then signed high-word fix-up
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   prod_hi_corr;
  logic                corr_sub_b, corr_sub_a;

  always_comb begin
    prod = {s1_pp_hh, s1_pp_ll}
         + {{HALF_W{1'b0}}, s1_pp_lh, {HALF_W{1'b0}}}
         + {{HALF_W{1'b0}}, s1_pp_hl, {HALF_W{1'b0}}};
    corr_sub_b = s1_sign_a && ((s1_mode == MODE_MULXSS) || (s1_mode == MODE_MULXSU));
    corr_sub_a = s1_sign_b && (s1_mode == MODE_MULXSS);
    prod_hi_corr = prod[2*DATA_W-1:DATA_W]
                 - (corr_sub_b ? s1_b : {DATA_W{1'b0}})
                 - (corr_sub_a ? s1_a : {DATA_W{1'b0}});
  end

  // Stage S2 registers
  logic              s2_valid;
  logic [DATA_W-1:0] s2_lo, s2_hi;
  logic              s2_is_mul;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid  <= 1'b0;
      s2_lo     <= '0;
      s2_hi     <= '0;
      s2_is_mul <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_lo     <= prod[DATA_W-1:0];
        s2_hi     <= prod_hi_corr;
        s2_is_mul <= (s1_mode == MODE_MUL);
      end
    end
  end

  // Stage S3: result only loads for a valid operation so it holds across bubbles
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        result <= s2_is_mul ? s2_lo : s2_hi;
      end
    end
  end

  assign busy = s1_valid | s2_valid | out_valid;

endmodule

`default_nettype wire
